// File: rtl/rfphoenix_icmiss.sv
// rfPhoenix I-cache lookup and line-refill controller (4-way, per-line valid flops).
// Define RFPHOENIX_ICMISS_LFSR_EN for LFSR victim selection; otherwise round-robin.
module rfphoenix_icmiss #(
    parameter int LINES = 128,
    parameter int WAYS  = 4,
    parameter int AWID  = 32,
    parameter int BEATS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ip_v,
    input  logic [AWID-1:0] ip,
    input  logic [AWID-7:0] tag [0:WAYS-1],
    input  logic            invall,
    output logic            hit,
    output logic [1:0]      hit_way,
    output logic            busy,
    output logic            mreq,
    output logic [AWID-1:0] madr,
    input  logic            mack,
    input  logic            mdat_v,
    input  logic [127:0]    mdat,
    output logic            dwr,
    output logic [1:0]      dway,
    output logic [AWID-1:0] dadr,
    output logic [127:0]    ddat,
    output logic            tag_wr,
    output logic [AWID-1:0] tag_ipo,
    output logic [1:0]      tag_way
);

    localparam int SETW = $clog2(LINES);
    localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, TAGW} state_t;

    state_t            state, state_n;
    logic              rip_v;
    logic [AWID-7:0]   rip_line;
    logic [LINES-1:0]  valid [WAYS];
    logic [1:0]        victim;
    logic [BW-1:0]     beat;
    logic              inv_pend;
`ifdef RFPHOENIX_ICMISS_LFSR_EN
    logic [7:0]        lfsr;
`else
    logic [1:0]        rr;
`endif

    logic [SETW-1:0]   set_rip;
    logic [SETW-1:0]   set_fill;
    logic [WAYS-1:0]   match;
    logic              any_match;
    logic              lookup_miss;
    logic [1:0]        match_way;
    logic              any_inv;
    logic [1:0]        inv_way;
    logic [1:0]        policy_way;
    logic [1:0]        victim_sel;
    logic              unused_ip;

    assign set_rip  = rip_line[SETW-1:0];
    assign set_fill = madr[6+SETW-1:6];

    // Lowest matching way and lowest invalid way of the looked-up set.
    always_comb begin
        match     = '0;
        match_way = '0;
        any_inv   = 1'b0;
        inv_way   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            match[i] = (tag[i] == rip_line) && valid[i][set_rip];
        end
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (match[i-1]) match_way = 2'(i - 1);
            if (!valid[i-1][set_rip]) begin
                any_inv = 1'b1;
                inv_way = 2'(i - 1);
            end
        end
    end

`ifdef RFPHOENIX_ICMISS_LFSR_EN
    assign policy_way = lfsr[1:0];
`else
    assign policy_way = rr;
`endif

    always_comb begin
        unused_ip   = ^ip[5:0];
        any_match   = |match;
        lookup_miss = rip_v && !any_match && (state == IDLE);
        victim_sel  = any_inv ? inv_way : policy_way;
    end

    always_comb begin
        state_n = state;
        hit     = 1'b0;
        hit_way = '0;
        busy    = lookup_miss || (state != IDLE);
        mreq    = 1'b0;
        dwr     = 1'b0;
        dway    = '0;
        dadr    = '0;
        ddat    = '0;
        tag_wr  = 1'b0;
        tag_ipo = '0;
        tag_way = '0;
        case (state)
            IDLE: begin
                if (rip_v && any_match) begin
                    hit     = 1'b1;
                    hit_way = match_way;
                end
                if (lookup_miss) state_n = REQ;
            end
            REQ: begin
                mreq = 1'b1;
                if (mack) state_n = FILL;
            end
            FILL: begin
                if (mdat_v) begin
                    dwr  = 1'b1;
                    dway = victim;
                    dadr = madr + AWID'({beat, 4'b0000});
                    ddat = mdat;
                    if (beat == LAST_BEAT) state_n = TAGW;
                end
            end
            TAGW: begin
                tag_wr  = 1'b1;
                tag_ipo = madr;
                tag_way = victim;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rip_v    <= 1'b0;
            rip_line <= '0;
            madr     <= '0;
            victim   <= '0;
            beat     <= '0;
            inv_pend <= 1'b0;
            for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
`ifdef RFPHOENIX_ICMISS_LFSR_EN
            lfsr     <= 8'hA5;
`else
            rr       <= '0;
`endif
        end else begin
            state    <= state_n;
            rip_v    <= ip_v;
            rip_line <= ip[AWID-1:6];
`ifdef RFPHOENIX_ICMISS_LFSR_EN
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
            if (lookup_miss) begin
                madr   <= {rip_line, 6'b000000};
                victim <= victim_sel;
            end
            if (dwr) beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
            if (state == TAGW) begin
                if (!inv_pend) valid[victim][set_fill] <= 1'b1;
                inv_pend <= 1'b0;
`ifndef RFPHOENIX_ICMISS_LFSR_EN
                rr <= rr + 2'd1;
`endif
            end
            // Placed last so a same-cycle invalidate overrides the TAGW valid set.
            if (invall) begin
                for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
                if (state == REQ || state == FILL) inv_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rfphoenix_icmiss.sv
// Directed bench for rfphoenix_icmiss (round-robin build) with a behavioural tag RAM
// and a table of lookup vectors; refills, invalidate and reset sequences are hand-written.
module tb_rfphoenix_icmiss;

    logic         clk;
    logic         rst;
    logic         ip_v;
    logic [31:0]  ip;
    logic [25:0]  tag_q [0:3];
    logic         invall;
    logic         hit;
    logic [1:0]   hit_way;
    logic         busy;
    logic         mreq;
    logic [31:0]  madr;
    logic         mack;
    logic         mdat_v;
    logic [127:0] mdat;
    logic         dwr;
    logic [1:0]   dway;
    logic [31:0]  dadr;
    logic [127:0] ddat;
    logic         tag_wr;
    logic [31:0]  tag_ipo;
    logic [1:0]   tag_way;

    logic [25:0]  tram [0:3][0:127];

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        hit;
        logic [1:0]  way;
        logic        busy;
        logic [1:0]  fill_way;
    } vec_t;

    vec_t tbl [16];

    rfphoenix_icmiss #(.LINES(128), .WAYS(4), .AWID(32), .BEATS(4)) dut (
        .clk(clk), .rst(rst), .ip_v(ip_v), .ip(ip), .tag(tag_q), .invall(invall),
        .hit(hit), .hit_way(hit_way), .busy(busy), .mreq(mreq), .madr(madr),
        .mack(mack), .mdat_v(mdat_v), .mdat(mdat), .dwr(dwr), .dway(dway),
        .dadr(dadr), .ddat(ddat), .tag_wr(tag_wr), .tag_ipo(tag_ipo), .tag_way(tag_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag RAM with registered read; read-before-write within a cycle.
    initial begin
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 128; s++) tram[w][s] = '0;
        for (int w = 0; w < 4; w++) tag_q[w] = '0;
    end
    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) tag_q[w] <= tram[w][ip[12:6]];
        if (tag_wr) tram[tag_way][tag_ipo[12:6]] <= tag_ipo[31:6];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic v, input logic [31:0] a);
        ip_v = v;
        ip   = a;
        step();
        ip_v = 1'b0;
    endtask

    // Call right after a lookup that reported a miss.
    task automatic do_refill(input logic [31:0] a, input logic [1:0] w,
                             input bit inv_mid, input int mack_delay);
        logic [127:0] d;
        chk("mreq_before_req", {127'd0, mreq}, 128'd0);
        step();
        chk("mreq_rise", {127'd0, mreq}, 128'd1);
        chk("madr", {96'd0, madr}, {96'd0, a});
        for (int i = 0; i < mack_delay; i++) begin
            mdat_v = 1'b1;
            #1;
            chk("dwr_outside_fill", {127'd0, dwr}, 128'd0);
            step();
            mdat_v = 1'b0;
            chk("mreq_hold", {127'd0, mreq}, 128'd1);
            chk("madr_hold", {96'd0, madr}, {96'd0, a});
        end
        mack = 1'b1;
        step();
        mack = 1'b0;
        chk("mreq_drop", {127'd0, mreq}, 128'd0);
        for (int b = 0; b < 4; b++) begin
            d      = {32'hD0D0_0000 + 32'(b), a, ~a, 32'(b)};
            mdat_v = 1'b1;
            mdat   = d;
            invall = inv_mid && (b == 1);
            #1;
            chk("dwr", {127'd0, dwr}, 128'd1);
            chk("dadr", {96'd0, dadr}, {96'd0, a + 32'(16 * b)});
            chk("dway", {126'd0, dway}, {126'd0, w});
            chk("ddat", ddat, d);
            step();
            invall = 1'b0;
        end
        mdat_v = 1'b0;
        chk("tag_wr", {127'd0, tag_wr}, 128'd1);
        chk("tag_ipo", {96'd0, tag_ipo}, {96'd0, a});
        chk("tag_way", {126'd0, tag_way}, {126'd0, w});
        step();
        chk("tag_wr_drop", {127'd0, tag_wr}, 128'd0);
        chk("busy_end", {127'd0, busy}, 128'd0);
    endtask

    task automatic chk_lookup(input string nm, input logic h, input logic [1:0] w, input logic b);
        chk({nm, "_hit"}, {127'd0, hit}, {127'd0, h});
        chk({nm, "_way"}, {126'd0, hit_way}, {126'd0, w});
        chk({nm, "_busy"}, {127'd0, busy}, {127'd0, b});
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h9000, 1'b1, 2'd0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 32'h3000, 1'b1, 2'd1, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 32'h5004, 1'b1, 2'd2, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 32'h7030, 1'b1, 2'd3, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 32'h9000, 1'b0, 2'd0, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 32'h1040, 1'b0, 2'd0, 1'b1, 2'd0};
        tbl[6]  = '{1'b1, 32'h1040, 1'b1, 2'd0, 1'b0, 2'd0};
        tbl[7]  = '{1'b1, 32'h1000, 1'b0, 2'd0, 1'b1, 2'd2};
        tbl[8]  = '{1'b1, 32'h1000, 1'b1, 2'd2, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 32'h5000, 1'b0, 2'd0, 1'b1, 2'd3};
        tbl[10] = '{1'b1, 32'h5000, 1'b1, 2'd3, 1'b0, 2'd0};
        tbl[11] = '{1'b1, 32'h3000, 1'b1, 2'd1, 1'b0, 2'd0};
        tbl[12] = '{1'b1, 32'h7000, 1'b0, 2'd0, 1'b1, 2'd0};
        tbl[13] = '{1'b1, 32'h9000, 1'b0, 2'd0, 1'b1, 2'd1};
        tbl[14] = '{1'b1, 32'h7000, 1'b1, 2'd0, 1'b0, 2'd0};
        tbl[15] = '{1'b1, 32'h1010, 1'b1, 2'd2, 1'b0, 2'd0};

        rst = 1'b1; ip_v = 1'b0; ip = '0; invall = 1'b0;
        mack = 1'b0; mdat_v = 1'b0; mdat = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_lookup("reset", 1'b0, 2'd0, 1'b0);
        chk("reset_mreq", {127'd0, mreq}, 128'd0);
        chk("reset_madr", {96'd0, madr}, 128'd0);
        chk("reset_dwr", {127'd0, dwr}, 128'd0);
        chk("reset_dadr", {96'd0, dadr}, 128'd0);
        chk("reset_tag_wr", {127'd0, tag_wr}, 128'd0);
        chk("reset_tag_ipo", {96'd0, tag_ipo}, 128'd0);
        rst = 1'b1;
        step();

        // First miss with a slow memory acknowledge, then hit on re-lookup.
        lookup(1'b1, 32'h1000);
        chk_lookup("miss1000", 1'b0, 2'd0, 1'b1);
        do_refill(32'h1000, 2'd0, 1'b0, 5);
        lookup(1'b1, 32'h1000);
        chk_lookup("hit1000", 1'b1, 2'd0, 1'b0);

        // Fill remaining ways of set 64, then force a replacement.
        for (int i = 1; i < 4; i++) begin
            lookup(1'b1, 32'h1000 + 32'(i) * 32'h2000);
            chk_lookup("miss_fill", 1'b0, 2'd0, 1'b1);
            do_refill(32'h1000 + 32'(i) * 32'h2000, 2'(i), 1'b0, 1);
        end
        lookup(1'b1, 32'h9000);
        chk_lookup("miss9000", 1'b0, 2'd0, 1'b1);
        do_refill(32'h9000, 2'd0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            lookup(tbl[i].v, tbl[i].a);
            chk_lookup($sformatf("vec%0d", i), tbl[i].hit, tbl[i].way, tbl[i].busy);
            if (tbl[i].busy) do_refill(tbl[i].a & ~32'h3F, tbl[i].fill_way, 1'b0, 0);
        end

        // Invalidate during a fill: tag still written, line and older lines miss.
        lookup(1'b1, 32'h2000);
        chk_lookup("miss2000", 1'b0, 2'd0, 1'b1);
        do_refill(32'h2000, 2'd0, 1'b1, 0);
        lookup(1'b1, 32'h2000);
        chk_lookup("inv_miss2000", 1'b0, 2'd0, 1'b1);
        do_refill(32'h2000, 2'd0, 1'b0, 0);
        lookup(1'b1, 32'h2000);
        chk_lookup("hit2000", 1'b1, 2'd0, 1'b0);
        lookup(1'b1, 32'h1000);
        chk_lookup("inv_miss1000", 1'b0, 2'd0, 1'b1);

        // Reset in the middle of the fill just started.
        step();
        chk("rst_req_mreq", {127'd0, mreq}, 128'd1);
        mack = 1'b1;
        step();
        mack = 1'b0;
        mdat_v = 1'b1;
        mdat = 128'h1234;
        step();
        chk("rst_pre_dwr", {127'd0, dwr}, 128'd1);
        rst = 1'b0;
        #1;
        chk("rst_mreq", {127'd0, mreq}, 128'd0);
        chk("rst_dwr", {127'd0, dwr}, 128'd0);
        chk("rst_tag_wr", {127'd0, tag_wr}, 128'd0);
        chk("rst_madr", {96'd0, madr}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_tag_wr", {127'd0, tag_wr}, 128'd0);
        end
        mdat_v = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_tag_wr", {127'd0, tag_wr}, 128'd0);
            chk("post_rst_busy", {127'd0, busy}, 128'd0);
        end
        lookup(1'b1, 32'h1000);
        chk_lookup("post_rst_miss", 1'b0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
